// File: rtl/rr_grant_pkg.sv
// Shared types and helpers for the round-robin grant controller.
// The optional grant watchdog is enabled with the RR_GRANT_TIMEOUT_EN macro.
package rr_grant_pkg;

  localparam int DEF_N   = 4;
  localparam int MAX_N   = 16;
  localparam int MAX_IDW = 4;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // The OR accumulation is exact for one-hot or zero inputs.
  function automatic logic [MAX_IDW-1:0] onehot2idx(input logic [MAX_N-1:0] oh);
    logic [MAX_IDW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | MAX_IDW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate req by ptr, find first set, un-rotate.
// Shared by the grant controller; no state.
module rr_pick
  import rr_grant_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   win_oh,
  output logic [IDW-1:0] win_idx
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [IDW-1:0] ffs_idx;
  logic [IDW:0]   idx_sum;
  logic           any_req;

  // Doubling the vector makes the rotation exact for any N, not just powers of two.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[{1'b0, ptr} +: N];
  assign any_req = |req;

  always_comb begin
    ffs_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) ffs_idx = IDW'(i);
    end
  end

  always_comb begin
    idx_sum = {1'b0, ffs_idx} + {1'b0, ptr};
    if (idx_sum >= (IDW+1)'(N)) idx_sum = idx_sum - (IDW+1)'(N);
    win_idx = IDW'(idx_sum);
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_oh
    assign win_oh[gi] = any_req && (win_idx == IDW'(gi));
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin owner arbiter for one shared resource with registered one-hot grant.
// Define RR_GRANT_TIMEOUT_EN to add the MAX_HOLD watchdog that revokes long grants.
module rr_grant_ctrl
  import rr_grant_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int IDW      = $clog2(N),
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           busy_q, busy_d;
  logic [N-1:0]   pick_oh;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] ptr_after;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx)
  );

  assign ptr_after = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + 1'b1;

`ifdef RR_GRANT_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;
`else
  // MAX_HOLD only matters when the watchdog is built in.
  localparam int UNUSED_MAX_HOLD = MAX_HOLD;
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
    ptr_d    = ptr_q;
`ifdef RR_GRANT_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d    = pick_oh;
          gnt_id_d = pick_idx;
          busy_d   = 1'b1;
          state_d  = GRANT;
`ifdef RR_GRANT_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      GRANT: begin
        if (!req[gnt_id_q]) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_after;
          state_d = IDLE;
        end
`ifdef RR_GRANT_TIMEOUT_EN
        else if (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) begin
          gnt_d     = '0;
          busy_d    = 1'b0;
          ptr_d     = ptr_after;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
      ptr_q    <= '0;
`ifdef RR_GRANT_TIMEOUT_EN
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
      ptr_q    <= ptr_d;
`ifdef RR_GRANT_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;
`ifdef RR_GRANT_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  a_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_busy   : assert property (@(posedge clk) disable iff (!rst_n) busy_q == (|gnt_q));
  a_id     : assert property (@(posedge clk) disable iff (!rst_n)
                              busy_q |-> (32'(gnt_id_q) == 32'(onehot2idx(MAX_N'(gnt_q)))));

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Scoreboard bench for rr_grant_ctrl: directed scenarios plus random traffic vs a cycle model.
module tb_rr_grant_ctrl;

  localparam int N        = 4;
  localparam int IDW      = 2;
  localparam int MAX_HOLD = 16;
`ifdef RR_GRANT_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout;

  rr_grant_ctrl #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    int           id;
    logic         busy;
    logic         tmo;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   obs[$];
  int   tmo_seen = 0;
  logic prev_busy = 1'b0;

  // Reference model: who owns the resource, where the scan starts, how long held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_tmo   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: actual=%0h required=%0h @%0t", name, act, want, $time);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_tmo   = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    exp_t e;
    m_tmo = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end
      m_hold = 0;
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else if (TMO_EN && m_hold == MAX_HOLD - 1) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_tmo   = 1'b1;
    end else begin
      m_hold++;
    end
    e.gnt  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    e.id   = m_owner;
    e.busy = (m_owner >= 0);
    e.tmo  = m_tmo;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic [N-1:0] r);
    @(negedge clk);
    req = r;
    model_step(r);
  endtask

  // Monitor: one scoreboard entry is consumed per clock after each edge.
  always begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("gnt", 32'(gnt), 32'(mon_e.gnt));
        chk("busy", 32'(busy), 32'(mon_e.busy));
        chk("timeout", 32'(timeout), 32'(mon_e.tmo));
        if (mon_e.busy) chk("gnt_id", 32'(gnt_id), 32'(mon_e.id));
        $display("txn t=%0t req=%b gnt=%b id=%0d busy=%b tmo=%b", $time, req, gnt, gnt_id, busy, timeout);
      end
      if (busy && !prev_busy) obs.push_back(int'(gnt_id));
      if (timeout) tmo_seen++;
      prev_busy = busy;
    end else begin
      prev_busy = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] r;
    int guard;

    // 1. Reset with every requester asserted
    rst_n = 1'b0;
    req   = 4'b1111;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_gnt_id", 32'(gnt_id), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    req   = '0;
    rst_n = 1'b1;
    model_reset();

    // 3. Round robin from ptr=0, each owner keeps the grant 3 cycles
    obs.delete();
    guard = 0;
    while (guard < 100) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_hold == 2) r[m_owner] = 1'b0;
      cycle(r);
      guard++;
      if (obs.size() >= 5) break;
    end
    cycle(4'b0000);
    chk("rr_count", 32'(obs.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("rr_order", (i < obs.size()) ? 32'(obs[i]) : 32'hFFFF, 32'(i % N));
    end
    cycle(4'b0000);

    // 2. Single request, then release
    cycle(4'b0100);
    @(posedge clk);
    #2;
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_id", 32'(gnt_id), 32'd2);
    cycle(4'b0000);
    @(posedge clk);
    #2;
    chk("single_release", 32'(gnt), 32'h0);

    // 4. ptr is now 3; requester 3 absent is skipped, then wrap to 0 and 1
    obs.delete();
    guard = 0;
    while (guard < 40 && obs.size() < 2) begin
      r = 4'b0011;
      if (m_owner >= 0 && m_hold == 1) r[m_owner] = 1'b0;
      cycle(r);
      guard++;
    end
    cycle(4'b0000);
    chk("wrap_count", 32'(obs.size()), 32'd2);
    chk("wrap_first", (obs.size() > 0) ? 32'(obs[0]) : 32'hFFFF, 32'd0);
    chk("wrap_second", (obs.size() > 1) ? 32'(obs[1]) : 32'hFFFF, 32'd1);
    cycle(4'b0000);

    // 5. No preemption by req[0], then asynchronous reset mid-grant
    cycle(4'b0010);
    repeat (3) cycle(4'b0011);
    #2;
    chk("nopreempt_gnt", 32'(gnt), 32'h2);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    req   = '0;
    rst_n = 1'b1;
    model_reset();

    // 6. Requester 2 holds for 20 cycles
    tmo_seen = 0;
    repeat (20) cycle(4'b0100);
    cycle(4'b0000);
    cycle(4'b0000);
    chk("hold_timeouts", 32'(tmo_seen), TMO_EN ? 32'd1 : 32'd0);

    // Random traffic: owners mostly keep their request, others toggle freely
    for (int i = 0; i < 400; i++) begin
      r = N'($urandom);
      if (m_owner >= 0) r[m_owner] = ($urandom_range(15) != 0);
      cycle(r);
    end
    cycle(4'b0000);
    cycle(4'b0000);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #3;
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
